// File: rtl/exe_stage.sv
// LoongArch EXE stage: ID->EXE pipe register, ALU / 33x33 multiply / radix-2 divide, forwarding to ID.
// Latency: ALU and multiply 1 cycle in EXE; divide holds EXE for 1 IDLE + DIV_CYCLES BUSY cycles.
// Backpressure: valid/allowin; allowin drops while a divide is in flight or MEM refuses the result.

module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    // Single-cycle ALU, one-hot op: {lui,sra,srl,sll,xor,or,nor,and,sltu,slt,sub,add}.
    // Latency: combinational.
    // Backpressure: none; the enclosing stage owns the handshake.

    logic        op_add, op_sub, op_slt, op_sltu, op_and, op_nor;
    logic        op_or, op_xor, op_sll, op_srl, op_sra, op_lui;
    logic        adder_sub;
    logic [31:0] adder_b;
    logic [32:0] adder_out;
    logic        slt_res, sltu_res;
    logic [31:0] sll_res, srl_res, sra_res;

    assign {op_lui, op_sra, op_srl, op_sll, op_xor, op_or,
            op_nor, op_and, op_sltu, op_slt, op_sub, op_add} = alu_op;

    // Compares share the adder in subtract mode; carry-out gives the unsigned borrow.
    assign adder_sub = op_sub | op_slt | op_sltu;
    assign adder_b   = adder_sub ? ~alu_src2 : alu_src2;
    assign adder_out = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, adder_sub};

    assign slt_res  = (alu_src1[31] & ~alu_src2[31])
                    | (~(alu_src1[31] ^ alu_src2[31]) & adder_out[31]);
    assign sltu_res = ~adder_out[32];

    assign sll_res = alu_src1 << alu_src2[4:0];
    assign srl_res = alu_src1 >> alu_src2[4:0];
    assign sra_res = $signed(alu_src1) >>> alu_src2[4:0];

    always_comb begin
        alu_result = '0;
        if (op_add | op_sub) alu_result = adder_out[31:0];
        if (op_slt)          alu_result = {31'd0, slt_res};
        if (op_sltu)         alu_result = {31'd0, sltu_res};
        if (op_and)          alu_result = alu_src1 & alu_src2;
        if (op_nor)          alu_result = ~(alu_src1 | alu_src2);
        if (op_or)           alu_result = alu_src1 | alu_src2;
        if (op_xor)          alu_result = alu_src1 ^ alu_src2;
        if (op_sll)          alu_result = sll_res;
        if (op_srl)          alu_result = srl_res;
        if (op_sra)          alu_result = sra_res;
        if (op_lui)          alu_result = alu_src2;
    end
endmodule

module exe_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_to_exe_valid,
    output logic        exe_allowin,
    input  logic [31:0] id_pc,
    input  logic [11:0] id_alu_op,
    input  logic [31:0] id_alu_src1,
    input  logic [31:0] id_alu_src2,
    input  logic [6:0]  id_md_op,
    input  logic [5:0]  id_rf_all,
    input  logic        id_res_from_mem,
    input  logic        id_mem_we,
    input  logic [31:0] id_rkd_value,
    input  logic        mem_allowin,
    output logic        exe_to_mem_valid,
    output logic [31:0] exe_pc,
    output logic [31:0] exe_result,
    output logic        exe_res_from_mem,
    output logic        exe_mem_we,
    output logic [31:0] exe_rkd_value,
    output logic [5:0]  exe_rf_all,
    output logic [37:0] exe_fwd,
    output logic        exe_is_load
);
    // Execute stage proper: pipe register plus result select over alu / mul / div.
    // Latency: 1 cycle for ALU and multiply; a divide presents its result 33 cycles after entering EXE.
    // Backpressure: exe_allowin = ~exe_valid | (ready_go & mem_allowin); results hold until MEM takes them.

    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    logic        exe_valid;
    logic [31:0] pc_r;
    logic [11:0] alu_op_r;
    logic [31:0] src1_r;
    logic [31:0] src2_r;
    logic [6:0]  md_op_r;
    logic [5:0]  rf_all_r;
    logic        res_from_mem_r;
    logic        mem_we_r;
    logic [31:0] rkd_r;

    logic        accept;
    logic        is_div;
    logic        div_signed;
    logic        ready_go;

    div_state_t  div_state, div_state_nxt;
    logic [CW-1:0] count;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] div_b;
    logic        qsign;
    logic        rsign;
    logic [31:0] a_abs, b_abs;
    logic [32:0] rq;
    logic [32:0] diff;
    logic        ge;
    logic        div_by_zero;
    logic [31:0] quotient, remainder;

    logic        mul_signed;
    logic [63:0] mul_a, mul_b, mul_prod;
    logic [31:0] alu_result;

    assign is_div     = exe_valid & (|md_op_r[6:3]);
    assign div_signed = md_op_r[3] | md_op_r[4];
    assign ready_go   = ~is_div | (div_state == DIV_DONE);

    assign exe_allowin      = ~exe_valid | (ready_go & mem_allowin);
    assign exe_to_mem_valid = exe_valid & ready_go;
    assign accept           = id_to_exe_valid & exe_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            exe_valid <= 1'b0;
            rf_all_r  <= '0;
        end else begin
            if (exe_allowin) exe_valid <= id_to_exe_valid;
            if (accept)      rf_all_r  <= id_rf_all;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pc_r           <= id_pc;
            alu_op_r       <= id_alu_op;
            src1_r         <= id_alu_src1;
            src2_r         <= id_alu_src2;
            md_op_r        <= id_md_op;
            res_from_mem_r <= id_res_from_mem;
            mem_we_r       <= id_mem_we;
            rkd_r          <= id_rkd_value;
        end
    end

    alu u_alu (
        .alu_op     (alu_op_r),
        .alu_src1   (src1_r),
        .alu_src2   (src2_r),
        .alu_result (alu_result)
    );

    // 33x33 product: only the low 64 bits are ever used, so it is formed directly at 64 bits.
    assign mul_signed = md_op_r[1];
    assign mul_a      = {{32{mul_signed & src1_r[31]}}, src1_r};
    assign mul_b      = {{32{mul_signed & src2_r[31]}}, src2_r};
    assign mul_prod   = mul_a * mul_b;

    always_ff @(posedge clk) begin
        if (reset) div_state <= DIV_IDLE;
        else       div_state <= div_state_nxt;
    end

    always_comb begin
        div_state_nxt = div_state;
        case (div_state)
            DIV_IDLE: if (is_div)            div_state_nxt = DIV_BUSY;
            DIV_BUSY: if (count == CNT_LAST) div_state_nxt = DIV_DONE;
            DIV_DONE: if (mem_allowin)       div_state_nxt = DIV_IDLE;
            default:                         div_state_nxt = DIV_IDLE;
        endcase
    end

    assign a_abs = (div_signed & src1_r[31]) ? (~src1_r + 32'd1) : src1_r;
    assign b_abs = (div_signed & src2_r[31]) ? (~src2_r + 32'd1) : src2_r;

    // Restoring step. rq < 2*div_b, so rq[32] set already implies rq >= div_b.
    assign rq   = {div_r, div_q[31]};
    assign diff = rq - {1'b0, div_b};
    assign ge   = rq[32] | ~diff[32];

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (div_state == DIV_IDLE && is_div) begin
            count <= '0;
            div_q <= a_abs;
            div_r <= '0;
            div_b <= b_abs;
            qsign <= div_signed & (src1_r[31] ^ src2_r[31]);
            rsign <= div_signed & src1_r[31];
        end else if (div_state == DIV_BUSY) begin
            div_q <= {div_q[30:0], ge};
            div_r <= ge ? diff[31:0] : rq[31:0];
            count <= count + CW'(1);
        end
    end

    // Divide by zero reports all-ones / the untouched dividend, bypassing sign fixup.
    assign div_by_zero = (div_b == 32'd0);
    assign quotient    = div_by_zero ? 32'hFFFF_FFFF : (qsign ? (~div_q + 32'd1) : div_q);
    assign remainder   = div_by_zero ? src1_r        : (rsign ? (~div_r + 32'd1) : div_r);

    always_comb begin
        exe_result = alu_result;
        if (md_op_r[0])                    exe_result = mul_prod[31:0];
        else if (md_op_r[1] | md_op_r[2])  exe_result = mul_prod[63:32];
        else if (md_op_r[3] | md_op_r[5])  exe_result = quotient;
        else if (md_op_r[4] | md_op_r[6])  exe_result = remainder;
    end

    assign exe_pc           = pc_r;
    assign exe_rkd_value    = rkd_r;
    assign exe_rf_all       = rf_all_r;
    // MEM fires the SRAM request straight from these, so they must be dead during stalls and bubbles.
    assign exe_res_from_mem = res_from_mem_r & exe_to_mem_valid;
    assign exe_mem_we       = mem_we_r & exe_to_mem_valid;
    assign exe_is_load      = exe_valid & res_from_mem_r;
    assign exe_fwd          = {exe_valid & rf_all_r[5] & ready_go, rf_all_r[4:0], exe_result};
endmodule
